// File: rtl/clkdiv_speed_ctrl.sv
// Speed-change controller for the divide-by-2/4 clock divider: switches div4not2 only on a
// falling edge of the divided clock, then settles before acknowledging. Optional macro: CLKDIV_SPEED_TIMEOUT_EN.
module clkdiv_speed_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          DEFAULT_DIV4   = 1'b1
) (
  input  logic clkin,
  input  logic rst,
  input  logic req_valid,
  input  logic req_div4,
  input  logic clkout_mon,
  output logic div4not2,
  output logic req_ack,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, SETTLE, ACK} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state;
  logic       mon_prev;
  logic       ack_prev;
  logic       target_div4;
  logic [7:0] settle_cnt;
  logic       safe_edge;
  logic       timeout_hit;

  // A falling edge of the divided clock is the only point where the divider can change ratio cleanly.
  assign safe_edge = mon_prev & ~clkout_mon;

`ifdef CLKDIV_SPEED_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] timeout_cnt;

  assign timeout_hit = (state == WAIT_EDGE) && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge clkin) begin
    if (rst) begin
      timeout_cnt <= '0;
      err         <= 1'b0;
    end else begin
      if (state != WAIT_EDGE) begin
        timeout_cnt <= '0;
      end else if (timeout_cnt != 8'hFF) begin
        timeout_cnt <= timeout_cnt + 8'd1;
      end
      // A safe edge in the timeout cycle means the switch was not forced.
      if (timeout_hit && !safe_edge) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state       <= IDLE;
      div4not2    <= DEFAULT_DIV4;
      target_div4 <= DEFAULT_DIV4;
      req_ack     <= 1'b0;
      busy        <= 1'b0;
      mon_prev    <= 1'b0;
      ack_prev    <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      mon_prev <= clkout_mon;
      ack_prev <= req_ack;
      req_ack  <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle right after an ack ignores req_valid so a late-dropping requester is not re-accepted.
          if (req_valid && !ack_prev) begin
            busy <= 1'b1;
            if (req_div4 == div4not2) begin
              state   <= ACK;
              req_ack <= 1'b1;
            end else begin
              target_div4 <= req_div4;
              state       <= WAIT_EDGE;
            end
          end
        end
        WAIT_EDGE: begin
          if (safe_edge || timeout_hit) begin
            div4not2   <= target_div4;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end
          if (settle_cnt <= 8'd1) begin
            state   <= ACK;
            req_ack <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_speed_ctrl.sv
// Self-checking bench for clkdiv_speed_ctrl: a logged clkout_mon history and per-request
// arithmetic (first safe edge, timeout, settle delay) predict every acknowledgement.
module tb_clkdiv_speed_ctrl;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 16;
  localparam bit DEF     = 1'b1;

  logic clkin = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_div4 = 1'b0;
  logic clkout_mon = 1'b0;
  logic div4not2, req_ack, busy, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mon_mode = 0;  // 0 random, 1 real divider, 2 stuck low, 3 sparse random
  bit mon_hist [0:65535];
  bit rst_hist [0:65535];
  logic div_out = 1'b0;
  logic div_phase = 1'b0;
  bit model_div = DEF;
  bit model_err = 1'b0;

  clkdiv_speed_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .DEFAULT_DIV4  (DEF)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .req_valid (req_valid),
    .req_div4  (req_div4),
    .clkout_mon(clkout_mon),
    .div4not2  (div4not2),
    .req_ack   (req_ack),
    .busy      (busy),
    .err       (err)
  );

  always #5 clkin = ~clkin;

  // History of what the DUT sampled at the end of each cycle, plus a behavioural 50:50 divider.
  always @(posedge clkin) begin
    mon_hist[cyc] <= clkout_mon;
    rst_hist[cyc] <= rst;
    cyc <= cyc + 1;
    if (div4not2 === 1'b1) begin
      div_phase <= ~div_phase;
      if (div_phase) div_out <= ~div_out;
    end else begin
      div_phase <= 1'b0;
      div_out   <= ~div_out;
    end
  end

  task automatic next_cycle();
    @(negedge clkin);
    case (mon_mode)
      0: clkout_mon = 1'($urandom_range(0, 1));
      1: clkout_mon = div_out;
      2: clkout_mon = 1'b0;
      default: clkout_mon = ($urandom_range(0, 31) == 0);
    endcase
  endtask

  // Cycle of the switch for a request accepted in cycle n, or -1 when no switch occurs up to 'last'.
  function automatic int find_switch(input int n, input int last, output bit forced);
    forced = 1'b0;
    for (int e = n + 1; e <= last; e++) begin
      if (mon_hist[e-1] && !mon_hist[e] && !rst_hist[e-1]) return e;
`ifdef CLKDIV_SPEED_TIMEOUT_EN
      if (e - n == TIMEOUT) begin
        forced = 1'b1;
        return e;
      end
`endif
    end
    return -1;
  endfunction

  task automatic test_request(input bit d, input int mode, input string name);
    int n, a, chg, e, exp_a, exp_chg;
    bit forced, busy_ok;
    mon_mode = mode;
    next_cycle();
    n = cyc;
    req_valid = 1'b1;
    req_div4 = d;
    a = -1;
    chg = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      next_cycle();
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (chg < 0 && div4not2 !== model_div) chg = cyc;
      if (req_ack === 1'b1) begin
        a = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (a < 0) begin
      errors++;
      $display("FAIL %s_ack_wait: no req_ack within 1000 cycles of request at cycle %0d", name, n);
      return;
    end
    if (d == model_div) begin
      exp_a = n + 1;
      exp_chg = -1;
    end else begin
      e = find_switch(n, a, forced);
      exp_a = e + 1 + SETTLE;
      exp_chg = e + 1;
      model_div = d;
      if (forced) model_err = 1'b1;
    end
    if (a !== exp_a) begin
      errors++;
      $display("FAIL %s_ack_cycle: got cycle %0d expected %0d", name, a, exp_a);
    end
    checks++;
    if (chg !== exp_chg) begin
      errors++;
      $display("FAIL %s_switch_cycle: got cycle %0d expected %0d", name, chg, exp_chg);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s_busy_during: got busy low before ack expected high", name);
    end
    next_cycle();
    checks++;
    if (busy !== 1'b0 || req_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_ack: got busy=%0b ack=%0b expected 0 0", name, busy, req_ack);
    end
    checks++;
    if (div4not2 !== model_div || err !== model_err) begin
      errors++;
      $display("FAIL %s_final: got div4not2=%0b err=%0b expected %0b %0b",
               name, div4not2, err, model_div, model_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 2) rst = 1'b0;
      checks++;
      if (div4not2 !== DEF || busy !== 1'b0 || req_ack !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_values[%0d]: got div=%0b busy=%0b ack=%0b err=%0b expected %0b 0 0 0",
                 i, div4not2, busy, req_ack, err, DEF);
      end
    end
    model_div = DEF;
    model_err = 1'b0;
  endtask

  task automatic test_same_mode();
    test_request(model_div, 0, "same_mode");
  endtask

  task automatic test_divider();
    logic prev;
    logic s [0:9];
    test_request(1'b0, 1, "div_to_2");
    prev = div_out;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      checks++;
      if (div_out === prev) begin
        errors++;
        $display("FAIL div2_toggle[%0d]: got %0b expected %0b", i, div_out, ~prev);
      end
      prev = div_out;
    end
    test_request(1'b1, 1, "div_to_4");
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      s[i] = div_out;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s[i+2] === s[i] || (s[i+1] !== s[i] && s[i+2] !== s[i+1])) begin
        errors++;
        $display("FAIL div4_period[%0d]: got %0b%0b%0b expected period of 4", i, s[i], s[i+1], s[i+2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mon_mode = 0;
    next_cycle();
    req_valid = 1'b1;
    req_div4 = model_div;
    next_cycle();
    checks++;
    if (req_ack !== 1'b1) begin
      errors++;
      $display("FAIL hold_ack: got %0b expected 1", req_ack);
    end
    next_cycle();
    next_cycle();
    checks++;
    if (req_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_reaccept: got ack=%0b busy=%0b expected 0 0", req_ack, busy);
    end
    req_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit stray;
    mon_mode = 0;
    next_cycle();
    req_valid = 1'b1;
    req_div4 = ~model_div;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      next_cycle();
      if (div4not2 !== model_div) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_switch: got no switch expected one within 300 cycles");
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    req_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    checks++;
    if (div4not2 !== DEF || busy !== 1'b0 || req_ack !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_values: got div=%0b busy=%0b ack=%0b err=%0b expected %0b 0 0 0",
               div4not2, busy, req_ack, err, DEF);
    end
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (req_ack !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL rst_mid_no_ack: got req_ack after reset expected none");
    end
    model_div = DEF;
    model_err = 1'b0;
    test_request(~DEF, 0, "after_reset");
  endtask

`ifdef CLKDIV_SPEED_TIMEOUT_EN
  task automatic test_timeout();
    test_request(~model_div, 2, "timeout");
    checks++;
    if (model_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_forced: got model err=%0b expected 1", model_err);
    end
    test_request(~model_div, 0, "err_sticky");
  endtask
`else
  task automatic test_timeout();
    bit bad;
    mon_mode = 2;
    next_cycle();
    req_valid = 1'b1;
    req_div4 = ~model_div;
    bad = 1'b0;
    next_cycle();
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      if (busy !== 1'b1 || req_ack !== 1'b0 || err !== 1'b0 || div4not2 !== model_div) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_timeout_wait: got progress or err without a safe edge expected waiting");
    end
    rst = 1'b1;
    req_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    model_div = DEF;
    model_err = 1'b0;
    next_cycle();
  endtask
`endif

  task automatic test_random();
    int gap;
    for (int k = 0; k < 25; k++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) next_cycle();
      test_request(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 0 : 3, "random");
    end
  endtask

  initial begin
    test_reset();
    test_same_mode();
    test_divider();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
